// File: rtl/gpr_file_sb_if.sv
// gpr_file_sb_if: read, write and issue signals between issue/writeback and the register file.
interface gpr_file_sb_if #(
  parameter int XLEN = 32,
  parameter int GPRS = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  localparam int AW = $clog2(GPRS);
  logic                 ready;
  logic [NRP*AW-1:0]    raddr;
  logic [NRP*XLEN-1:0]  rdata;
  logic [NRP-1:0]       rbusy;
  logic [NWP-1:0]       we;
  logic [NWP*AW-1:0]    waddr;
  logic [NWP*XLEN-1:0]  wdata;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  modport master (input ready, rdata, rbusy, output raddr, we, waddr, wdata, iss_valid, iss_addr);
  modport slave  (output ready, rdata, rbusy, input raddr, we, waddr, wdata, iss_valid, iss_addr);
endinterface

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: multi-port register file with write-to-read bypass, busy scoreboard and post-reset zero sweep.
module gpr_file_sb #(
  parameter int XLEN = 32,
  parameter int GPRS = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
) (
  input logic           clk,
  input logic           rst_n,
  gpr_file_sb_if.slave  bus
);
  localparam int AW = $clog2(GPRS);
  typedef enum logic {INIT, RUN} state_t;
  state_t               r_state;
  logic [AW-1:0]        r_cnt;
  logic [GPRS-1:0]      r_busy;
  logic                 r_ready;
  logic [XLEN-1:0]      r_mem [1:GPRS-1];
  logic [NWP-1:0]       w_wr;
  logic [NRP*XLEN-1:0]  w_rdata;
  logic [NRP-1:0]       w_rbusy;
  // a write only counts in RUN and to a nonzero register
  always_comb begin
    for (int i = 0; i < NWP; i++)
      w_wr[i] = (r_state == RUN) && bus.we[i] && (bus.waddr[i*AW +: AW] != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= AW'(1);
      r_busy  <= '0;
      r_ready <= 1'b0;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(GPRS-1)) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NWP; i++)
        if (w_wr[i]) r_busy[bus.waddr[i*AW +: AW]] <= 1'b0;
      // issue is applied last so a new producer beats a same-cycle writeback
      if (bus.iss_valid && bus.iss_addr != '0) r_busy[bus.iss_addr] <= 1'b1;
    end
  end
  // storage is not reset; the sweep zeroes it, later ports override earlier ones
  always_ff @(posedge clk) begin
    if (r_state == INIT) r_mem[r_cnt] <= '0;
    else
      for (int i = 0; i < NWP; i++)
        if (w_wr[i]) r_mem[bus.waddr[i*AW +: AW]] <= bus.wdata[i*XLEN +: XLEN];
  end
  for (genvar j = 0; j < NRP; j++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic            w_hit;
    logic [XLEN-1:0] w_d;
    assign w_ra = bus.raddr[j*AW +: AW];
    always_comb begin
      w_hit = 1'b0;
      w_d   = (w_ra != '0) ? r_mem[w_ra] : '0;
      for (int i = 0; i < NWP; i++)
        if (w_wr[i] && bus.waddr[i*AW +: AW] == w_ra) begin
          w_hit = 1'b1;
          w_d   = bus.wdata[i*XLEN +: XLEN];
        end
    end
    assign w_rdata[j*XLEN +: XLEN] = (r_state == RUN) ? w_d : '0;
    assign w_rbusy[j] = (r_state == RUN) && r_busy[w_ra] && !w_hit;
  end
  assign bus.rdata = w_rdata;
  assign bus.rbusy = w_rbusy;
  assign bus.ready = r_ready;
endmodule
